// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   state_t     : controller FSM encoding (IDLE, CONV, COMMIT)
//   HEX_FONT    : active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SEG_OFF     : segment bus value with every segment (and dp) dark
//   bcd_digits(): BCD digit count needed to convert a w-bit unsigned value,
//                 ceil(w*log10(2)) plus one spare digit
package sevenseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Index n holds the glyph for nibble value n.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // 30103/100000 approximates log10(2) from above closely enough for any
  // practical word width.
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/sevenseg_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
//   clock : system clock
//   reset : synchronous active-low, aborts a conversion in progress
//   start : load din and begin converting (ignored while busy)
//   din   : unsigned binary value
//   busy  : high for exactly DATA_W cycles after the start edge
//   done  : high during the final shift cycle; bcd is final on the next cycle
//   bcd   : packed BCD result, digit 0 in bits [3:0]
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BCD_D  = bcd_digits(DATA_W)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    din,
  output logic                 busy,
  output logic                 done,
  output logic [4*BCD_D-1:0]   bcd
);

  localparam int CW = $clog2(DATA_W + 1);

  logic              r_busy;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_sr;
  logic [4*BCD_D-1:0] r_bcd;
  logic [4*BCD_D-1:0] w_adj;
  logic              w_load;

  assign w_load = start && !r_busy;

  // Add 3 to every digit that would reach 10 or more after the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < BCD_D; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(DATA_W);
    end else if (r_busy) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Datapath: load on start, then shift the adjusted BCD and input together.
  always_ff @(posedge clock) begin
    if (w_load) begin
      r_sr  <= din;
      r_bcd <= '0;
    end else if (r_busy) begin
      {r_bcd, r_sr} <= {w_adj[4*BCD_D-2:0], r_sr, 1'b0};
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == CW'(1));
  assign bcd  = r_bcd;

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Memory-mapped multi-digit seven-segment display controller.
//   clock    : system clock, all logic on posedge
//   reset    : synchronous active-low
//   wr_en    : one-cycle store strobe to the display address
//   wr_data  : word to display
//   mode_dec : 0 = hex, 1 = unsigned decimal (sampled with wr_en)
//   blank_lz : 1 = blank leading zero digits (sampled live)
//   busy     : decimal conversion in progress
//   overflow : displayed value needs more than DIGITS digits
//   segments : {dp,g..a}, active-low
//   enables  : digit anodes, one-hot active-low
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mode_dec,
  input  logic              blank_lz,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        segments,
  output logic [DIGITS-1:0] enables
);

  localparam int BCD_D = bcd_digits(DATA_W);
  localparam int NW    = 4 * DIGITS;
  localparam int IW    = $clog2(DIGITS);
  localparam int SW    = $clog2(REFRESH_DIV);

  state_t              r_state, w_next;
  logic [NW-1:0]       r_nib;
  logic                r_ovf;
  logic                r_pend_vld;
  logic                r_pend_dec;
  logic [DATA_W-1:0]   r_pend_data;
  logic [SW-1:0]       r_scan;
  logic [IW-1:0]       r_idx;
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_en;

  logic                w_src_vld;
  logic                w_src_dec;
  logic [DATA_W-1:0]   w_src_data;
  logic                w_start;
  logic                w_load_hex;
  logic                w_commit;
  logic                w_pend_wr;
  logic                w_pend_clr;
  logic                w_eng_busy;
  logic                w_eng_done;
  logic [4*BCD_D-1:0]  w_bcd;
  logic [3:0]          w_cur_nib;
  logic                w_blank;

  // A fresh write always beats an older pending one (last write wins).
  assign w_src_vld  = wr_en | r_pend_vld;
  assign w_src_dec  = wr_en ? mode_dec : r_pend_dec;
  assign w_src_data = wr_en ? wr_data  : r_pend_data;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .BCD_D  (BCD_D)
  ) u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (w_start),
    .din   (w_src_data),
    .busy  (w_eng_busy),
    .done  (w_eng_done),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_load_hex = 1'b0;
    w_commit   = 1'b0;
    w_pend_wr  = 1'b0;
    w_pend_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_src_vld) begin
          w_pend_clr = 1'b1;
          if (w_src_dec) begin
            w_start = 1'b1;
            w_next  = ST_CONV;
          end else begin
            w_load_hex = 1'b1;
          end
        end
      end
      ST_CONV: begin
        if (wr_en) begin
          w_pend_wr = 1'b1;
        end
        // done marks the final shift, so the result is ready in COMMIT.
        if (w_eng_done) begin
          w_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
        w_next   = ST_IDLE;
        if (w_src_vld && w_src_dec) begin
          w_start    = 1'b1;
          w_pend_clr = 1'b1;
          w_next     = ST_CONV;
        end else if (w_src_vld) begin
          // A hex write cannot load in the same cycle as the commit; park it
          // so IDLE applies it next cycle.
          w_pend_wr = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pend_vld <= 1'b0;
    end else if (w_pend_wr) begin
      r_pend_vld <= 1'b1;
    end else if (w_pend_clr) begin
      r_pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_pend_wr) begin
      r_pend_data <= w_src_data;
      r_pend_dec  <= w_src_dec;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_nib <= '0;
      r_ovf <= 1'b0;
    end else if (w_load_hex) begin
      r_nib <= NW'(w_src_data);
      r_ovf <= (w_src_data >> NW) != '0;
    end else if (w_commit) begin
      r_nib <= NW'(w_bcd);
      r_ovf <= (w_bcd >> NW) != '0;
    end
  end

  // Digit i>0 is a leading zero when it and every digit above it are zero.
  assign w_cur_nib = r_nib[{r_idx, 2'b00} +: 4];
  assign w_blank   = blank_lz && (r_idx != '0) &&
                     ((r_nib >> {r_idx, 2'b00}) == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_seg  <= SEG_OFF;
      r_en   <= '1;
    end else begin
      if (r_scan == SW'(REFRESH_DIV - 1)) begin
        r_scan <= '0;
        r_idx  <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
      r_en  <= ~(DIGITS'(1) << r_idx);
      r_seg <= w_blank ? SEG_OFF : {1'b1, ~HEX_FONT[w_cur_nib]};
    end
  end

  assign busy     = w_eng_busy;
  assign overflow = r_ovf;
  assign segments = r_seg;
  assign enables  = r_en;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed, table-driven bench for sevenseg_scan_ctrl. u_dut (8 digits) carries
// the display checks; u_dut4 (4 digits) shares the inputs and covers the scan
// sequence and 4-digit overflow.
module tb_sevenseg_scan_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        mode_dec = 1'b0;
  logic        blank_lz = 1'b0;

  logic        busy, overflow;
  logic [7:0]  segments, enables;
  logic        busy4, overflow4;
  logic [7:0]  segments4;
  logic [3:0]  enables4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sevenseg_scan_ctrl #(.DIGITS(8), .DATA_W(32), .REFRESH_DIV(4)) u_dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .mode_dec(mode_dec), .blank_lz(blank_lz), .busy(busy),
    .overflow(overflow), .segments(segments), .enables(enables)
  );

  sevenseg_scan_ctrl #(.DIGITS(4), .DATA_W(32), .REFRESH_DIV(4)) u_dut4 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .mode_dec(mode_dec), .blank_lz(blank_lz), .busy(busy4),
    .overflow(overflow4), .segments(segments4), .enables(enables4)
  );

  typedef struct {
    logic [31:0]     data;
    logic            dec;
    logic            blank;
    logic [7:0][7:0] segs;   // expected segments, [i] = digit i
    logic            ovf;
    logic            ovf4;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] d, input logic dec);
    @(posedge clock); #1;
    wr_en = 1'b1; wr_data = d; mode_dec = dec;
    @(posedge clock); #1;
    wr_en = 1'b0;
  endtask

  task automatic read_frame(output logic [7:0][7:0] g);
    g = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        if (enables == ~(8'd1 << i)) g[i] = segments;
      end
    end
  endtask

  vec_t            vecs [7];
  logic [7:0][7:0] got;
  int              nb;
  int              busy_cyc, rises, saw7, n_d0;
  logic            busy_q;
  logic [7:0]      last_d0;
  logic [7:0]      d0_log [4];

  initial begin
    vecs[0] = '{32'h1234ABCD, 1'b0, 1'b0, 64'hF9A4B0998883C6A1, 1'b0, 1'b1};
    vecs[1] = '{32'd12345678, 1'b1, 1'b0, 64'hF9A4B0999282F880, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 1'b1, 1'b0, 64'h90999082F8A49092, 1'b1, 1'b1};
    vecs[3] = '{32'h00000042, 1'b0, 1'b1, 64'hFFFFFFFFFFFF99A4, 1'b0, 1'b0};
    vecs[4] = '{32'h00000000, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFC0, 1'b0, 1'b0};
    vecs[5] = '{32'h00000000, 1'b0, 1'b0, 64'hC0C0C0C0C0C0C0C0, 1'b0, 1'b0};
    vecs[6] = '{32'd99,       1'b1, 1'b1, 64'hFFFFFFFFFFFF9090, 1'b0, 1'b0};

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_segments", segments, 8'hFF);
    chk("rst_enables",  enables,  8'hFF);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_enables4", enables4, 4'hF);

    // Scan order on the 4-digit instance
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("first_cycle_enables4", enables4, 4'hF);
    for (int k = 0; k <= 16; k++) begin
      logic [3:0] e;
      @(negedge clock);
      e = ~(4'd1 << ((k / 4) % 4));
      chk($sformatf("scan4_k%0d", k), enables4, e);
    end

    // Table-driven display vectors
    for (int v = 0; v < 7; v++) begin
      blank_lz = vecs[v].blank;
      wr(vecs[v].data, vecs[v].dec);
      if (vecs[v].dec) begin
        nb = 0;
        @(negedge clock);
        while (busy && nb < 200) begin
          nb++;
          @(negedge clock);
        end
        chk($sformatf("v%0d_busy_len", v), nb, 32);
      end else begin
        @(negedge clock);
        chk($sformatf("v%0d_busy_hex", v), busy, 1'b0);
      end
      repeat (3) @(negedge clock);
      read_frame(got);
      for (int i = 0; i < 8; i++)
        chk($sformatf("v%0d_digit%0d", v, i), got[i], vecs[v].segs[i]);
      chk($sformatf("v%0d_overflow", v), overflow, vecs[v].ovf);
      chk($sformatf("v%0d_overflow4", v), overflow4, vecs[v].ovf4);
    end

    // Collision: 99 converts, 7 is superseded by 55, 55 converts once
    blank_lz = 1'b1;
    wr(32'd0, 1'b0);
    repeat (40) @(negedge clock);
    busy_cyc = 0; rises = 0; saw7 = 0; n_d0 = 0;
    busy_q = 1'b0; last_d0 = 8'h00;
    fork
      begin
        wr(32'd99, 1'b1);
        repeat (3) @(posedge clock);
        wr(32'd7, 1'b1);
        repeat (2) @(posedge clock);
        wr(32'd55, 1'b1);
      end
      begin
        for (int c = 0; c < 150; c++) begin
          @(negedge clock);
          if (busy) busy_cyc++;
          if (busy && !busy_q) rises++;
          busy_q = busy;
          if (enables == 8'hFE) begin
            if (segments == 8'hF8) saw7 = 1;
            if (segments != last_d0) begin
              if (n_d0 < 4) d0_log[n_d0] = segments;
              n_d0++;
              last_d0 = segments;
            end
          end
        end
      end
    join
    chk("coll_busy_cycles", busy_cyc, 64);
    chk("coll_conversions", rises, 2);
    chk("coll_seven_shown", saw7, 0);
    chk("coll_d0_changes", n_d0, 3);
    if (n_d0 >= 3) begin
      chk("coll_d0_first",  d0_log[0], 8'hC0);
      chk("coll_d0_second", d0_log[1], 8'h90);
      chk("coll_d0_third",  d0_log[2], 8'h92);
    end
    read_frame(got);
    chk("coll_final_frame", got, 64'hFFFFFFFFFFFF9292);

    // Reset during conversion
    blank_lz = 1'b0;
    wr(32'd12345678, 1'b1);
    repeat (9) @(negedge clock);
    chk("midconv_busy", busy, 1'b1);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("abort_segments", segments, 8'hFF);
    chk("abort_enables",  enables,  8'hFF);
    chk("abort_busy",     busy,     1'b0);
    chk("abort_overflow", overflow, 1'b0);
    rises = 0; busy_q = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (busy && !busy_q) rises++;
      busy_q = busy;
    end
    chk("abort_no_restart", rises, 0);
    read_frame(got);
    chk("abort_frame", got, 64'hC0C0C0C0C0C0C0C0);
    chk("abort_overflow_late", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
